mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Memory-access stage with the mem_wb pipeline register, directly downstream of the ex_mem interface. It consumes the ex_mem outputs: regwrite and memwrite flags, destination register, address, store data and ALU result. It performs data-memory loads and stores over a req/ack handshake, stalling upstream while an access is outstanding. It presents registered write-back signals (enable, register index, data) that drive the register file write port.

Parameters:
DW, 16, data and address width
RW, 4, destination register index width
TIMEOUT, 16, max cycles dmem_req is held without dmem_ack (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
valid_in  in  1  ex_mem holds a live instruction
set_regwrite_in  in  1  instruction writes a register
set_memwrite_in  in  1  instruction is a store
set_memread_in  in  1  instruction is a load
destreg_in  in  RW  destination register
addr_in  in  DW  data-memory address
store_data_in  in  DW  store data
result_in  in  DW  ALU result
stall_out  out  1  hold ex_mem and earlier stages
dmem_req  out  1  memory request
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  DW  request address
dmem_wdata  out  DW  write data
dmem_ack  in  1  request completed this cycle; dmem_rdata valid
dmem_rdata  in  DW  load data
wb_valid_out  out  1  one-cycle pulse per retired instruction
wb_regwrite_out  out  1  register write enable (qualified by wb_valid_out)
wb_destreg_out  out  RW  register index
wb_data_out  out  DW  data to write
err_out  out  1  sticky access-timeout flag

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous and active-low.
- Reset: state IDLE. All outputs 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_*, stall_out and err_out.
- Reset mid-access: dmem_req drops immediately, asynchronously. Any late dmem_ack after release is ignored while in IDLE.
- FSM states: IDLE and ACCESS.
- IDLE, valid_in=0: wb_valid_out=0 next cycle.
- IDLE, valid_in=1, no mem op: registered pass-through, 1-cycle latency. Next cycle: wb_valid_out=1, wb_regwrite_out=set_regwrite_in, wb_destreg_out=destreg_in, wb_data_out=result_in.
- IDLE, valid_in=1 with memread or memwrite:
  - stall_out=1 combinationally in this cycle.
  - Latch destreg, regwrite, result, addr and wdata; set we=memwrite; go to ACCESS.
  - dmem_req=1 from the next cycle.
- Both memread and memwrite set: treated as a store. wb_data_out is result_in; dmem_rdata is never used.
- ACCESS:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until dmem_ack is sampled high.
  - Inputs are ignored in this state.
  - stall_out=1 in every ACCESS cycle except the ack cycle, where stall_out=0 so upstream advances on the same edge.
- On the dmem_ack edge:
  - dmem_req goes to 0; state returns to IDLE.
  - Next cycle: wb_valid_out=1. wb_data_out is dmem_rdata for a load, or the latched result for a store. wb_regwrite_out is the latched regwrite flag; a store with regwrite=1 writes the result.
- Minimum load/store latency (ack in the first req cycle): valid at edge N, req during N+1, wb_valid_out at N+2.
- A new instruction is accepted only in IDLE. Back-to-back memory ops therefore cost 2 cycles minimum each.
- wb_valid_out is a single-cycle pulse. wb_regwrite_out, wb_destreg_out and wb_data_out hold their last values when wb_valid_out=0.
- No hardwired zero register: destreg 0 is written like any other.
- Addresses are passed unmodified; no alignment checks, no wrap handling.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: a counter runs during ACCESS. If TIMEOUT cycles of dmem_req elapse with no ack:
  - dmem_req drops and state returns to IDLE; stall_out=0 in that final cycle.
  - Next cycle: wb_valid_out pulses with wb_regwrite_out=0.
  - err_out sets and stays 1 until reset.
- Undefined: no counter; ACCESS waits indefinitely; err_out is tied to 0.

Test Plan:
- ALU pass-through: valid_in=1, regwrite=1, destreg=3, result=16'h1234 at edge N → wb_valid_out=1, wb_destreg_out=3, wb_data_out=16'h1234 at N+1; stall_out=0 throughout.
- Load, ack after 3 cycles: memread, addr=16'h00F0, destreg=5, dmem_rdata=16'hBEEF → dmem_req high for 3 cycles with addr 00F0 and we=0; stall high in all but the ack cycle; then wb_data_out=16'hBEEF, wb_destreg_out=5.
- Store: memwrite, addr=16'h0010, store_data=16'hA5A5, regwrite=0, ack in the first cycle → dmem_we=1, dmem_wdata=16'hA5A5 for one cycle; wb_valid_out=1 with wb_regwrite_out=0.
- Back-to-back load then ALU op → the ALU op is retired exactly one cycle after the load's wb pulse; it is neither duplicated nor lost.
- reset_n low during ACCESS with req high → dmem_req=0 with no clock edge needed; after release, an ack pulse produces no wb_valid_out.
- MEM_TIMEOUT_EN, TIMEOUT=16, no ack → req drops after 16 cycles; wb_valid_out pulses with regwrite=0; err_out=1 and stays set until reset.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and
// the data memory (slave).
interface mem_wb_stage_if #(
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus mem_wb register: loads/stores over a req/ack bus,
// stalling upstream while an access is outstanding. MEM_TIMEOUT_EN adds an access timeout.
module mem_wb_stage #(
  parameter int DW      = 16,
  parameter int RW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          valid_in,
  input  logic          set_regwrite_in,
  input  logic          set_memwrite_in,
  input  logic          set_memread_in,
  input  logic [RW-1:0] destreg_in,
  input  logic [DW-1:0] addr_in,
  input  logic [DW-1:0] store_data_in,
  input  logic [DW-1:0] result_in,
  output logic          stall_out,
  mem_wb_stage_if.master dmem,
  output logic          wb_valid_out,
  output logic          wb_regwrite_out,
  output logic [RW-1:0] wb_destreg_out,
  output logic [DW-1:0] wb_data_out,
  output logic          err_out
);
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          mem_op, finish, timeout_hit;
  logic          we_q, load_q, regwrite_q;
  logic [DW-1:0] addr_q, wdata_q, result_q;
  logic [RW-1:0] destreg_q;

  assign mem_op = valid_in & (set_memread_in | set_memwrite_in);
  assign finish = (state_q == ACCESS) & (dmem.ack | timeout_hit);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op) state_d = ACCESS;
      ACCESS:  if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req follows the state register, so async reset drops it without a clock
  always_comb begin
    dmem.req  = (state_q == ACCESS);
    stall_out = (state_q == IDLE) ? mem_op : ~finish;
  end

  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      we_q       <= 1'b0;
      load_q     <= 1'b0;
      regwrite_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      result_q   <= '0;
      destreg_q  <= '0;
    end else if (state_q == IDLE && mem_op) begin
      we_q       <= set_memwrite_in;
      load_q     <= set_memread_in & ~set_memwrite_in;  // read+write acts as a store
      regwrite_q <= set_regwrite_in;
      addr_q     <= addr_in;
      wdata_q    <= store_data_in;
      result_q   <= result_in;
      destreg_q  <= destreg_in;
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wb_valid_out    <= 1'b0;
      wb_regwrite_out <= 1'b0;
      wb_destreg_out  <= '0;
      wb_data_out     <= '0;
    end else begin
      wb_valid_out <= 1'b0;
      if (state_q == IDLE && valid_in && !mem_op) begin
        wb_valid_out    <= 1'b1;
        wb_regwrite_out <= set_regwrite_in;
        wb_destreg_out  <= destreg_in;
        wb_data_out     <= result_in;
      end else if (finish) begin
        wb_valid_out    <= 1'b1;
        wb_regwrite_out <= regwrite_q & dmem.ack;  // a timed-out access never writes
        wb_destreg_out  <= destreg_q;
        wb_data_out     <= (load_q && dmem.ack) ? dmem.rdata : result_q;
      end
    end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
  logic          err_q;

  // fires in the TIMEOUT-th req cycle, so req is high for exactly TIMEOUT cycles
  assign timeout_hit = (state_q == ACCESS) & ~dmem.ack & (tmo_cnt == CW'(TIMEOUT - 1));
  assign err_out     = err_q;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state_q == ACCESS) ? tmo_cnt + 1'b1 : '0;
      if (timeout_hit) err_q <= 1'b1;
    end
`else
  assign timeout_hit = 1'b0;
  assign err_out     = 1'b0;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; inputs driven and outputs sampled on the falling edge.
module tb_mem_wb_stage;
  localparam int DW = 16;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          valid_in, set_regwrite_in, set_memwrite_in, set_memread_in;
  logic [RW-1:0] destreg_in;
  logic [DW-1:0] addr_in, store_data_in, result_in;
  logic          stall_out, wb_valid_out, wb_regwrite_out, err_out;
  logic [RW-1:0] wb_destreg_out;
  logic [DW-1:0] wb_data_out;
  int            n_chk = 0;
  int            n_pass = 0;

  mem_wb_stage_if #(.DW(DW)) dmem ();

  mem_wb_stage #(.DW(DW), .RW(RW), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in),
    .set_regwrite_in(set_regwrite_in), .set_memwrite_in(set_memwrite_in),
    .set_memread_in(set_memread_in), .destreg_in(destreg_in), .addr_in(addr_in),
    .store_data_in(store_data_in), .result_in(result_in), .stall_out(stall_out),
    .dmem(dmem.master), .wb_valid_out(wb_valid_out), .wb_regwrite_out(wb_regwrite_out),
    .wb_destreg_out(wb_destreg_out), .wb_data_out(wb_data_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic rw, input logic mw, input logic mr,
                       input logic [RW-1:0] d, input logic [DW-1:0] a,
                       input logic [DW-1:0] sd, input logic [DW-1:0] r);
    valid_in = v; set_regwrite_in = rw; set_memwrite_in = mw; set_memread_in = mr;
    destreg_in = d; addr_in = a; store_data_in = sd; result_in = r;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; idle_in(); dmem.ack = 1'b0; dmem.rdata = '0;
    #12;
    n_chk++;
    if ({dmem.req, dmem.we, dmem.addr, dmem.wdata, stall_out, err_out} !== '0)
      $display("FAIL reset_dmem: got req=%b we=%b addr=%h wdata=%h stall=%b err=%b want all 0",
               dmem.req, dmem.we, dmem.addr, dmem.wdata, stall_out, err_out);
    else n_pass++;
    n_chk++;
    if ({wb_valid_out, wb_regwrite_out, wb_destreg_out, wb_data_out} !== '0)
      $display("FAIL reset_wb: got v=%b rw=%b d=%h data=%h want all 0",
               wb_valid_out, wb_regwrite_out, wb_destreg_out, wb_data_out);
    else n_pass++;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 16'h0000, 16'h0000, 16'h1234);
    #1;
    n_chk++;
    if (stall_out !== 1'b0) $display("FAIL alu_stall: got %b want 0", stall_out); else n_pass++;
    @(negedge clk); idle_in();
    n_chk++;
    if ({wb_valid_out, wb_regwrite_out, wb_destreg_out, wb_data_out} !== {1'b1, 1'b1, 4'd3, 16'h1234})
      $display("FAIL alu_wb: got v=%b rw=%b d=%h data=%h want v=1 rw=1 d=3 data=1234",
               wb_valid_out, wb_regwrite_out, wb_destreg_out, wb_data_out);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({wb_valid_out, wb_data_out, stall_out} !== {1'b0, 16'h1234, 1'b0})
      $display("FAIL alu_pulse: got v=%b data=%h stall=%b want v=0 data=1234 stall=0",
               wb_valid_out, wb_data_out, stall_out);
    else n_pass++;
  endtask

  task automatic test_load();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 16'h00F0, 16'h0000, 16'h7777);
    #1;
    n_chk++;
    if ({stall_out, dmem.req} !== 2'b10)
      $display("FAIL load_accept: got stall=%b req=%b want stall=1 req=0", stall_out, dmem.req);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) begin dmem.ack = 1'b1; dmem.rdata = 16'hBEEF; end
      #1;
      n_chk++;
      if ({dmem.req, dmem.we, dmem.addr, stall_out} !== {1'b1, 1'b0, 16'h00F0, (c != 2)})
        $display("FAIL load_access%0d: got req=%b we=%b addr=%h stall=%b want req=1 we=0 addr=00f0 stall=%b",
                 c, dmem.req, dmem.we, dmem.addr, stall_out, (c != 2));
      else n_pass++;
    end
    @(negedge clk); dmem.ack = 1'b0; idle_in();
    n_chk++;
    if ({dmem.req, wb_valid_out, wb_regwrite_out, wb_destreg_out, wb_data_out} !==
        {1'b0, 1'b1, 1'b1, 4'd5, 16'hBEEF})
      $display("FAIL load_wb: got req=%b v=%b rw=%b d=%h data=%h want req=0 v=1 rw=1 d=5 data=beef",
               dmem.req, wb_valid_out, wb_regwrite_out, wb_destreg_out, wb_data_out);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_store(input logic rw, input logic mr, input logic [DW-1:0] res);
    drive(1'b1, rw, 1'b1, mr, 4'd7, 16'h0010, 16'hA5A5, res);
    @(negedge clk); idle_in(); dmem.ack = 1'b1; dmem.rdata = 16'hFFFF;
    #1;
    n_chk++;
    if ({dmem.req, dmem.we, dmem.addr, dmem.wdata, stall_out} !== {1'b1, 1'b1, 16'h0010, 16'hA5A5, 1'b0})
      $display("FAIL store_bus(rw=%b mr=%b): got req=%b we=%b addr=%h wdata=%h stall=%b want 1 1 0010 a5a5 0",
               rw, mr, dmem.req, dmem.we, dmem.addr, dmem.wdata, stall_out);
    else n_pass++;
    @(negedge clk); dmem.ack = 1'b0;
    n_chk++;
    if ({dmem.req, wb_valid_out, wb_regwrite_out, wb_destreg_out, wb_data_out} !== {1'b0, 1'b1, rw, 4'd7, res})
      $display("FAIL store_wb(rw=%b mr=%b): got req=%b v=%b rw=%b d=%h data=%h want req=0 v=1 rw=%b d=7 data=%h",
               rw, mr, dmem.req, wb_valid_out, wb_regwrite_out, wb_destreg_out, wb_data_out, rw, res);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0040, 16'h0000, 16'h0000);
    @(negedge clk); dmem.ack = 1'b1; dmem.rdata = 16'h1111;  // load stays presented while stalled
    #1;
    n_chk++;
    if (stall_out !== 1'b0) $display("FAIL b2b_ack_stall: got %b want 0", stall_out); else n_pass++;
    @(negedge clk); dmem.ack = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 16'h0000, 16'h0000, 16'h0099);
    #1;
    n_chk++;
    if ({wb_valid_out, wb_destreg_out, wb_data_out, stall_out} !== {1'b1, 4'd0, 16'h1111, 1'b0})
      $display("FAIL b2b_load_wb: got v=%b d=%h data=%h stall=%b want v=1 d=0 data=1111 stall=0",
               wb_valid_out, wb_destreg_out, wb_data_out, stall_out);
    else n_pass++;
    @(negedge clk); idle_in();
    n_chk++;
    if ({wb_valid_out, wb_regwrite_out, wb_destreg_out, wb_data_out} !== {1'b1, 1'b1, 4'd9, 16'h0099})
      $display("FAIL b2b_alu_wb: got v=%b rw=%b d=%h data=%h want v=1 rw=1 d=9 data=0099",
               wb_valid_out, wb_regwrite_out, wb_destreg_out, wb_data_out);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (wb_valid_out !== 1'b0) $display("FAIL b2b_no_dup: got v=%b want 0", wb_valid_out); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 16'h0200, 16'h0000, 16'h0000);
    @(negedge clk); idle_in();
    n_chk++;
    if (dmem.req !== 1'b1) $display("FAIL rst_mid_pre: got req=%b want 1", dmem.req); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if ({dmem.req, stall_out, dmem.addr} !== {1'b0, 1'b0, 16'h0000})
      $display("FAIL rst_mid_async: got req=%b stall=%b addr=%h want 0 0 0000", dmem.req, stall_out, dmem.addr);
    else n_pass++;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); dmem.ack = 1'b1; dmem.rdata = 16'hDEAD;
    @(negedge clk); dmem.ack = 1'b0;
    n_chk++;
    if ({wb_valid_out, dmem.req} !== 2'b00)
      $display("FAIL rst_mid_late_ack: got v=%b req=%b want 0 0", wb_valid_out, dmem.req);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({wb_valid_out, wb_data_out} !== {1'b0, 16'h0000})
      $display("FAIL rst_mid_quiet: got v=%b data=%h want 0 0000", wb_valid_out, wb_data_out);
    else n_pass++;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 16'h0300, 16'h0000, 16'h0000);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); idle_in();
      #1;
      n_chk++;
      if ({dmem.req, stall_out} !== {1'b1, (c != 15)})
        $display("FAIL tmo_cycle%0d: got req=%b stall=%b want req=1 stall=%b", c, dmem.req, stall_out, (c != 15));
      else n_pass++;
    end
    @(negedge clk);
    n_chk++;
    if ({dmem.req, wb_valid_out, wb_regwrite_out, err_out} !== 4'b0101)
      $display("FAIL tmo_end: got req=%b v=%b rw=%b err=%b want 0 1 0 1", dmem.req, wb_valid_out, wb_regwrite_out, err_out);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({err_out, wb_valid_out} !== 2'b10)
      $display("FAIL tmo_sticky: got err=%b v=%b want 1 0", err_out, wb_valid_out);
    else n_pass++;
    reset_n = 1'b0; #1;
    n_chk++;
    if (err_out !== 1'b0) $display("FAIL tmo_clear: got err=%b want 0", err_out); else n_pass++;
    @(negedge clk); reset_n = 1'b1; @(negedge clk);
  endtask
`else
  task automatic test_timeout();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 16'h0300, 16'h0000, 16'h0000);
    @(negedge clk); idle_in();
    repeat (20) @(negedge clk);
    n_chk++;
    if ({dmem.req, stall_out, wb_valid_out, err_out} !== 4'b1100)
      $display("FAIL no_tmo_wait: got req=%b stall=%b v=%b err=%b want 1 1 0 0", dmem.req, stall_out, wb_valid_out, err_out);
    else n_pass++;
    dmem.ack = 1'b1; dmem.rdata = 16'h3C3C;
    @(negedge clk); dmem.ack = 1'b0;
    n_chk++;
    if ({wb_valid_out, wb_regwrite_out, wb_destreg_out, wb_data_out, err_out} !== {1'b1, 1'b1, 4'd6, 16'h3C3C, 1'b0})
      $display("FAIL no_tmo_wb: got v=%b rw=%b d=%h data=%h err=%b want 1 1 6 3c3c 0",
               wb_valid_out, wb_regwrite_out, wb_destreg_out, wb_data_out, err_out);
    else n_pass++;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store(1'b0, 1'b0, 16'h5555);
    test_store(1'b1, 1'b1, 16'h0ABC);
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
